// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port load/store arbiter onto one single-port RAM with a bounded hold time
// Ports: clk; reset (asynchronous, active low);
//   per port n: reqn, storen, addrn, wdatan, byteSeln in; gntn out (grant in the same cycle);
//   rvalidn/rdatan out (load data one cycle after the grant);
//   RAM side: ramAddress, ramDataWrite, ramByteSelect, ramStore, ramLoad out; ramDataRead in.
// Config: define ROUND_ROBIN_EN so that idle-state ties go to the port not served last;
//   otherwise idle-state ties always go to port 0.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module memory_arbiter #(
  parameter int MAX_HOLD   = 4,
  parameter int DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  store0,
  input  logic                  store1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [3:0]            byteSel0,
  input  logic [3:0]            byteSel1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramDataWrite,
  output logic [3:0]            ramByteSelect,
  output logic                  ramStore,
  output logic                  ramLoad,
  input  logic [DATA_WIDTH-1:0] ramDataRead
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, tag_v_q, tag_v_d, tag_p_q, tag_p_d;
  logic [HW-1:0] hold_q, hold_d;
  logic any, win, tie, hold_max, same, win_st, gnt;
  always_comb begin
    any = req0 | req1;
    hold_max = hold_q == HW'(MAX_HOLD);
`ifdef ROUND_ROBIN_EN
    tie = ~last_q;
`else
    tie = 1'b0;
`endif
    // win is the winning port id; only meaningful when any is high
    win = state_q == OWN0 ? (req0 ? req1 & hold_max : 1'b1) :
          state_q == OWN1 ? (req1 ? ~(req0 & hold_max) : 1'b0) :
          (req0 & req1 ? tie : req1);
    same = (state_q == OWN0 & ~win) | (state_q == OWN1 & win);
    win_st = win ? store1 : store0;
    state_d = ~any ? IDLE : win ? OWN1 : OWN0;
    hold_d = ~any ? hold_q : ~same ? HW'(1) : hold_max ? hold_q : hold_q + HW'(1);
    last_d = any ? win : last_q;
    tag_v_d = any & ~win_st;
    tag_p_d = win;
  end
  // grants are gated by reset so the RAM side is quiet while reset is low
  assign gnt0 = reset & any & ~win;
  assign gnt1 = reset & any & win;
  assign gnt = gnt0 | gnt1;
  assign ramStore = gnt & win_st;
  assign ramLoad = gnt & ~win_st;
  assign ramAddress = gnt ? (win ? addr1 : addr0) : '0;
  assign ramDataWrite = gnt ? (win ? wdata1 : wdata0) : '0;
  assign ramByteSelect = gnt ? (win ? byteSel1 : byteSel0) : 4'b0;
  assign rvalid0 = tag_v_q & ~tag_p_q;
  assign rvalid1 = tag_v_q & tag_p_q;
  assign rdata0 = rvalid0 ? ramDataRead : '0;
  assign rdata1 = rvalid1 ? ramDataRead : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      hold_q <= '0;
      tag_v_q <= 1'b0;
      tag_p_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      hold_q <= hold_d;
      tag_v_q <= tag_v_d;
      tag_p_q <= tag_p_d;
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: vector table, directed corner sequences and random traffic against a reference model
module tb_memory_arbiter;
  localparam int DW = 32;
  localparam int MH = 4;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req0 = 0, req1 = 0, store0 = 0, store1 = 0;
  logic [DW-1:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [3:0] byteSel0 = '0, byteSel1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, ramStore, ramLoad;
  logic [DW-1:0] rdata0, rdata1, ramAddress, ramDataWrite;
  logic [3:0] ramByteSelect;
  logic [DW-1:0] ramDataRead = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.MAX_HOLD(MH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .store0(store0), .store1(store1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .byteSel0(byteSel0), .byteSel1(byteSel1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ramAddress(ramAddress), .ramDataWrite(ramDataWrite), .ramByteSelect(ramByteSelect),
    .ramStore(ramStore), .ramLoad(ramLoad), .ramDataRead(ramDataRead)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  // registered RAM read port
  always @(posedge clk) if (ramLoad) ramDataRead <= memf(ramAddress);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk({tag, " gnt0"}, 32'(gnt0), 0);
    chk({tag, " gnt1"}, 32'(gnt1), 0);
    chk({tag, " rvalid0"}, 32'(rvalid0), 0);
    chk({tag, " rvalid1"}, 32'(rvalid1), 0);
    chk({tag, " rdata0"}, rdata0, 0);
    chk({tag, " rdata1"}, rdata1, 0);
    chk({tag, " ramAddress"}, ramAddress, 0);
    chk({tag, " ramDataWrite"}, ramDataWrite, 0);
    chk({tag, " ramByteSelect"}, 32'(ramByteSelect), 0);
    chk({tag, " ramStore"}, 32'(ramStore), 0);
    chk({tag, " ramLoad"}, 32'(ramLoad), 0);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; store0 = 0; store1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; byteSel0 = '0; byteSel1 = '0;
  endtask

  // leaves time at 1ns after a rising edge, state freshly reset
  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r0, r1, s0, s1, g0, g1, v0, v1;
  } vec_t;
  vec_t tbl[20];

  function automatic vec_t mk(bit r0, bit r1, bit s0, bit s1, bit g0, bit g1, bit v0, bit v1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.s0 = s0; v.s1 = s1; v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  int owner, run, last, w;
  bit pv;
  int pp;
  logic [31:0] pa;

  initial begin
    // reset values while reset is held low, even with requests pending
    req0 = 1; req1 = 1;
    #3 all_zero("reset");
    do_reset();

    // directed: single port-0 load returns RAM data one cycle later
    req0 = 1; store0 = 0; addr0 = 32'h10;
    @(negedge clk);
    chk("ld gnt0", 32'(gnt0), 1);
    chk("ld gnt1", 32'(gnt1), 0);
    chk("ld ramLoad", 32'(ramLoad), 1);
    chk("ld ramAddress", ramAddress, 32'h10);
    @(posedge clk); #1 req0 = 0;
    @(negedge clk);
    chk("ld rvalid0", 32'(rvalid0), 1);
    chk("ld rdata0", rdata0, 32'hDEADBEEF);
    chk("ld rvalid1", 32'(rvalid1), 0);
    chk("ld rdata1", rdata1, 0);
    @(posedge clk); #1;

    // directed: port-1 byte store
    req1 = 1; store1 = 1; addr1 = 32'h20; wdata1 = 32'hAA; byteSel1 = 4'b0001;
    @(negedge clk);
    chk("st gnt1", 32'(gnt1), 1);
    chk("st ramStore", 32'(ramStore), 1);
    chk("st ramLoad", 32'(ramLoad), 0);
    chk("st ramByteSelect", 32'(ramByteSelect), 32'b0001);
    chk("st ramAddress", ramAddress, 32'h20);
    chk("st ramDataWrite", ramDataWrite, 32'hAA);
    @(posedge clk); #1 idle_inputs();
    @(negedge clk);
    chk("st rvalid1", 32'(rvalid1), 0);
    chk("st rvalid0", 32'(rvalid0), 0);
    @(posedge clk); #1;

    // directed: reset asserted right after a load grant discards the pending return
    req0 = 1; store0 = 0; addr0 = 32'h44;
    @(negedge clk);
    chk("rst ld gnt0", 32'(gnt0), 1);
    @(posedge clk); #1;
    reset = 0; req1 = 1;
    #2 all_zero("in reset");
    @(posedge clk); #1 idle_inputs();
    @(negedge clk) reset = 1;
    @(posedge clk); #1 all_zero("after release");
    @(negedge clk);
    chk("after release rvalid0", 32'(rvalid0), 0);
    @(posedge clk); #1;

    // directed: idle-state ties after reset
    do_reset();
    req0 = 1; req1 = 1;
    @(negedge clk);
    chk("tie1 gnt0", 32'(gnt0), 1);
    chk("tie1 gnt1", 32'(gnt1), 0);
    @(posedge clk); #1 idle_inputs();
    repeat (2) @(posedge clk);
    #1 req0 = 1; req1 = 1;
    @(negedge clk);
    chk("tie2 gnt0", 32'(gnt0), RR ? 0 : 1);
    chk("tie2 gnt1", 32'(gnt1), RR ? 1 : 0);
    @(posedge clk); #1 idle_inputs();

    // vector table, applied cycle by cycle from a fresh reset
    tbl[0] = mk(1, 1, 0, 0, 1, 0, 0, 0);
    tbl[1] = mk(1, 1, 0, 0, 1, 0, 1, 0);
    tbl[2] = mk(1, 1, 0, 0, 1, 0, 1, 0);
    tbl[3] = mk(1, 1, 0, 0, 1, 0, 1, 0);
    tbl[4] = mk(1, 1, 0, 0, 0, 1, 1, 0);
    tbl[5] = mk(1, 1, 0, 0, 0, 1, 0, 1);
    tbl[6] = mk(1, 1, 0, 0, 0, 1, 0, 1);
    tbl[7] = mk(1, 1, 0, 0, 0, 1, 0, 1);
    tbl[8] = mk(1, 1, 0, 0, 1, 0, 0, 1);
    tbl[9] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 0, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 1);
    tbl[14] = mk(1, 1, 0, 0, 1, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 1, 0);
    tbl[16] = mk(1, 1, 0, 0, !RR, RR, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, !RR, RR);
    tbl[18] = mk(0, 1, 0, 1, 0, 1, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();
    addr0 = 32'h100; addr1 = 32'h200;
    for (int i = 0; i < 20; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; store0 = tbl[i].s0; store1 = tbl[i].s1;
      @(negedge clk);
      chk($sformatf("vec%0d gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
      chk($sformatf("vec%0d gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
      chk($sformatf("vec%0d ramLoad", i), 32'(ramLoad),
          32'((tbl[i].g0 & ~tbl[i].s0) | (tbl[i].g1 & ~tbl[i].s1)));
      chk($sformatf("vec%0d rvalid0", i), 32'(rvalid0), 32'(tbl[i].v0));
      chk($sformatf("vec%0d rvalid1", i), 32'(rvalid1), 32'(tbl[i].v1));
      chk($sformatf("vec%0d rdata0", i), rdata0, tbl[i].v0 ? memf(32'h100) : 0);
      chk($sformatf("vec%0d rdata1", i), rdata1, tbl[i].v1 ? memf(32'h200) : 0);
      @(posedge clk); #1;
    end

    // random traffic against a reference model of the arbitration rules
    do_reset();
    owner = -1; last = 1; run = 0; pv = 0; pp = 0; pa = '0; w = -1;
    for (int i = 0; i < 1500; i++) begin
      if (!req0 || w == 0) begin
        req0 = $urandom_range(0, 9) < 6; store0 = 1'($urandom_range(0, 1));
        addr0 = $urandom; wdata0 = $urandom; byteSel0 = 4'($urandom_range(0, 15));
      end
      if (!req1 || w == 1) begin
        req1 = $urandom_range(0, 9) < 6; store1 = 1'($urandom_range(0, 1));
        addr1 = $urandom; wdata1 = $urandom; byteSel1 = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      if (!req0 && !req1) w = -1;
      else if (owner >= 0 && (owner == 0 ? req0 : req1))
        w = ((owner == 0 ? req1 : req0) && run >= MH) ? 1 - owner : owner;
      else if (req0 && req1) w = RR ? 1 - last : 0;
      else w = req0 ? 0 : 1;
      chk($sformatf("rnd%0d gnt0", i), 32'(gnt0), 32'(w == 0));
      chk($sformatf("rnd%0d gnt1", i), 32'(gnt1), 32'(w == 1));
      chk($sformatf("rnd%0d ramAddress", i), ramAddress, w == 0 ? addr0 : w == 1 ? addr1 : 0);
      chk($sformatf("rnd%0d ramDataWrite", i), ramDataWrite, w == 0 ? wdata0 : w == 1 ? wdata1 : 0);
      chk($sformatf("rnd%0d ramByteSelect", i), 32'(ramByteSelect),
          w == 0 ? 32'(byteSel0) : w == 1 ? 32'(byteSel1) : 0);
      chk($sformatf("rnd%0d ramStore", i), 32'(ramStore),
          32'(w == 0 ? store0 : w == 1 ? store1 : 1'b0));
      chk($sformatf("rnd%0d ramLoad", i), 32'(ramLoad),
          32'(w == 0 ? !store0 : w == 1 ? !store1 : 1'b0));
      chk($sformatf("rnd%0d rvalid0", i), 32'(rvalid0), 32'(pv && pp == 0));
      chk($sformatf("rnd%0d rvalid1", i), 32'(rvalid1), 32'(pv && pp == 1));
      chk($sformatf("rnd%0d rdata0", i), rdata0, (pv && pp == 0) ? memf(pa) : 0);
      chk($sformatf("rnd%0d rdata1", i), rdata1, (pv && pp == 1) ? memf(pa) : 0);
      pv = w >= 0 && !(w == 1 ? store1 : store0);
      pp = w;
      pa = w == 1 ? addr1 : addr0;
      if (w >= 0) begin
        run = (w == owner) ? (run < MH ? run + 1 : MH) : 1;
        owner = w;
        last = w;
      end else owner = -1;
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
